// File: rtl/synapse_weight_ctrl_if.sv
// Bundle between the synapse-weight learning scheduler and its neighbours:
// update request, learn enable and traces in; weights and status out.
interface synapse_weight_ctrl_if #(
    parameter int unsigned p_n         = 4,
    parameter int unsigned p_width     = 9,
    parameter int unsigned p_idx_width = 2
);
    logic                       i_update;
    logic                       i_learn_en;
    logic [p_n*p_width-1:0]     i_tr;
    logic [p_n*p_width-1:0]     o_weight;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_miss;
    logic [p_idx_width-1:0]     o_idx;

    // Neuron/label logic side: issues requests and supplies traces.
    modport master (
        output i_update,
        output i_learn_en,
        output i_tr,
        input  o_weight,
        input  o_busy,
        input  o_done,
        input  o_miss,
        input  o_idx
    );

    // Weight controller side.
    modport slave (
        input  i_update,
        input  i_learn_en,
        input  i_tr,
        output o_weight,
        output o_busy,
        output o_done,
        output o_miss,
        output o_idx
    );
endinterface

// File: rtl/synapse_weight_ctrl.sv
// Learning scheduler for a bank of p_n synapses. Owns the weight registers.
// An accepted update request snapshots all traces, then walks the bank one
// synapse per clock applying w <- w + ((tr - w) >>> p_eta_shift), saturated.
// Optional build macro WCTRL_LFSR_INIT_EN: after reset, an INIT walk loads
// the weights from a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1).
module synapse_weight_ctrl #(
    parameter int unsigned p_n         = 4,
    parameter int unsigned p_width     = 9,
    parameter int unsigned p_eta_shift = 2,
    parameter int unsigned p_idx_width = 2
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    synapse_weight_ctrl_if.slave bus
);

`ifdef WCTRL_LFSR_INIT_EN
    typedef enum logic [1:0] {StIdle, StWalk, StDone, StInit} state_e;
    localparam state_e StReset = StInit;
`else
    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;
    localparam state_e StReset = StIdle;
`endif

    // Mid-scale weight after reset.
    localparam logic [p_width-1:0]     WeightReset = p_width'(1) << (p_width - 1);
    localparam logic [p_idx_width-1:0] IdxLast     = p_idx_width'(p_n - 1);

    state_e                 state_q, state_d;
    logic [p_idx_width-1:0] idx_q, idx_d;
    logic [p_width-1:0]     weight_q [p_n];
    logic [p_width-1:0]     weight_d [p_n];
    logic [p_width-1:0]     snap_q   [p_n];
    logic [p_width-1:0]     snap_d   [p_n];
    logic                   miss_q, miss_d;
    logic                   request;

`ifdef WCTRL_LFSR_INIT_EN
    logic [15:0] lfsr_q, lfsr_d;
`endif

    // One learning step; the result always lies between w and tr, so the
    // clamp only guards against arithmetic corner cases.
    function automatic logic [p_width-1:0] learn_step(
        input logic [p_width-1:0] w,
        input logic [p_width-1:0] tr
    );
        logic signed [p_width:0]   diff;
        logic signed [p_width:0]   delta;
        logic signed [p_width+1:0] sum;
        diff  = $signed({1'b0, tr}) - $signed({1'b0, w});
        // Arithmetic shift floors: small negative diffs give -1, small
        // positive diffs give 0.
        delta = diff >>> p_eta_shift;
        sum   = $signed({2'b00, w}) + $signed({delta[p_width], delta});
        if (sum[p_width+1]) begin
            return '0;
        end else if (sum[p_width]) begin
            return '1;
        end else begin
            return sum[p_width-1:0];
        end
    endfunction

    assign request = bus.i_update && bus.i_learn_en;

`ifdef WCTRL_LFSR_INIT_EN
    // Galois LFSR free-runs one step per cycle.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
`endif

    // Next-state: FSM, walk index, weight and snapshot updates, miss pulse.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        weight_d = weight_q;
        snap_d   = snap_q;
        miss_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (request) begin
                    for (int k = 0; k < p_n; k++) begin
                        snap_d[k] = bus.i_tr[k*p_width +: p_width];
                    end
                    idx_d   = '0;
                    state_d = StWalk;
                end
            end
            StWalk: begin
                weight_d[idx_q] = learn_step(weight_q[idx_q], snap_q[idx_q]);
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + p_idx_width'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
`ifdef WCTRL_LFSR_INIT_EN
            StInit: begin
                weight_d[idx_q] = lfsr_q[p_width-1:0];
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + p_idx_width'(1);
                end
            end
`endif
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase

        // Any request arriving outside IDLE is dropped and flagged.
        if (state_q != StIdle && request) begin
            miss_d = 1'b1;
        end
    end

    // State, index, weights, snapshot and miss flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StReset;
            idx_q   <= '0;
            miss_q  <= 1'b0;
            for (int k = 0; k < p_n; k++) begin
                weight_q[k] <= WeightReset;
                snap_q[k]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            miss_q   <= miss_d;
            weight_q <= weight_d;
            snap_q   <= snap_d;
        end
    end

`ifdef WCTRL_LFSR_INIT_EN
    // LFSR register, reseeded on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Outputs come straight from registers so weights never glitch.
    always_comb begin
        for (int k = 0; k < p_n; k++) begin
            bus.o_weight[k*p_width +: p_width] = weight_q[k];
        end
        bus.o_busy = (state_q != StIdle);
        bus.o_done = (state_q == StDone);
        bus.o_miss = miss_q;
        bus.o_idx  = idx_q;
    end

endmodule
